// File: rtl/vdp_cpu_if.sv
`default_nettype none
// ============================================================================
// Module   : vdp_cpu_if
// Purpose  : CPU-side port interface of a TMS9918-style VDP. It decodes the
//            data and control ports, holds the address/register latch, the
//            auto-incrementing VRAM pointer, the read-ahead buffer, registers
//            0-7 and the status flags, and drives a req/ack handshake toward
//            the VRAM arbiter.
// Options  : define VDP_OVERRUN_CNT_EN to build the 8-bit saturating counter
//            of dropped data-port accesses (otherwise overrun_cnt is 8'h00).
// Revision : 1.0 - initial release
// ============================================================================
module vdp_cpu_if #(
  parameter logic [7:0] DATA_PORT = 8'hBE,
  parameter logic [7:0] CTRL_PORT = 8'hBF,
  parameter int         ADDR_BITS = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_edge,
  input  logic [7:0]           cpu_addr,
  input  logic [7:0]           cpu_dout,
  input  logic                 n_iowr,
  input  logic                 n_iord,
  output logic [7:0]           cpu_din,
  output logic                 vram_req,
  output logic                 vram_we,
  output logic [ADDR_BITS-1:0] vram_addr,
  output logic [7:0]           vram_wdata,
  input  logic [7:0]           vram_rdata,
  input  logic                 vram_ack,
  input  logic                 interrupt_flag,
  input  logic                 sprite_collision,
  input  logic                 too_many_sprites,
  input  logic [4:0]           sprite5,
  output logic [63:0]          regs,
  output logic                 n_int,
  output logic                 overrun,
  output logic [7:0]           overrun_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  // Port matches (combinational) and their sampled copies
  logic wr_data_m, wr_ctrl_m, rd_data_m, rd_ctrl_m;
  logic wr_data_prev_q, wr_ctrl_prev_q, rd_data_prev_q, rd_ctrl_prev_q;

  assign wr_data_m = (cpu_addr == DATA_PORT) && !n_iowr;
  assign wr_ctrl_m = (cpu_addr == CTRL_PORT) && !n_iowr;
  assign rd_data_m = (cpu_addr == DATA_PORT) && !n_iord;
  assign rd_ctrl_m = (cpu_addr == CTRL_PORT) && !n_iord;

  // Write start / read end events, qualified by the CPU clock-enable edge
  logic ev_dwr, ev_cwr, ev_drd_end, ev_crd_end;
  assign ev_dwr     = cpu_edge &&  wr_data_m && !wr_data_prev_q;
  assign ev_cwr     = cpu_edge &&  wr_ctrl_m && !wr_ctrl_prev_q;
  assign ev_drd_end = cpu_edge && !rd_data_m &&  rd_data_prev_q;
  assign ev_crd_end = cpu_edge && !rd_ctrl_m &&  rd_ctrl_prev_q;

  // Architectural state
  logic [7:0]           regs_q [8];
  logic [7:0]           latch_q;
  logic                 toggle_q;
  logic [ADDR_BITS-1:0] ptr_q;
  logic [7:0]           rbuf_q;
  logic                 f_q, c_q, f_d, c_d;
  logic                 n_int_q;
  state_t               state_q;
  logic                 req_q, we_q, overrun_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [7:0]           wdata_q;

  logic [ADDR_BITS-1:0] ptr_inc, setup_addr, rd_addr;
  logic                 setup_rd, rd_req, wr_req, busy, drop;

  assign ptr_inc    = ptr_q + ADDR_BITS'(1);
  assign setup_addr = ADDR_BITS'({cpu_dout[5:0], latch_q});
  // Second control byte with bits 7:6 = 00 is a read setup and prefetches
  assign setup_rd   = ev_cwr && toggle_q && !cpu_dout[7] && !cpu_dout[6];
  assign rd_req     = setup_rd || ev_drd_end;
  assign rd_addr    = ev_drd_end ? ptr_inc : setup_addr;
  assign wr_req     = ev_dwr;
  assign busy       = (state_q != ST_IDLE);
  // A request is dropped if the engine is busy; a write and a prefetch on the
  // same edge keep the write and drop the prefetch.
  assign drop       = (wr_req || rd_req) && (busy || (wr_req && rd_req));

  // Set has priority over a clear on the same clk
  assign f_d = interrupt_flag   || (f_q && !ev_crd_end);
  assign c_d = sprite_collision || (c_q && !ev_crd_end);

  // Sample port matches on each CPU edge for start/end detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_data_prev_q <= 1'b0;
      wr_ctrl_prev_q <= 1'b0;
      rd_data_prev_q <= 1'b0;
      rd_ctrl_prev_q <= 1'b0;
    end else if (cpu_edge) begin
      wr_data_prev_q <= wr_data_m;
      wr_ctrl_prev_q <= wr_ctrl_m;
      rd_data_prev_q <= rd_data_m;
      rd_ctrl_prev_q <= rd_ctrl_m;
    end
  end

  // Two-byte latch, register file and VRAM pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= 8'h00;
      latch_q  <= 8'h00;
      toggle_q <= 1'b0;
      ptr_q    <= '0;
    end else begin
      if (ev_cwr) begin
        if (!toggle_q) begin
          latch_q  <= cpu_dout;
          toggle_q <= 1'b1;
        end else begin
          toggle_q <= 1'b0;
          if (cpu_dout[7]) begin
            if (cpu_dout[5:3] == 3'b000) regs_q[cpu_dout[2:0]] <= latch_q;
          end else begin
            ptr_q <= setup_addr;
          end
        end
      end
      if (ev_dwr || ev_drd_end) begin
        toggle_q <= 1'b0;
        ptr_q    <= ptr_inc;
      end
      if (ev_crd_end) toggle_q <= 1'b0;
    end
  end

  // VRAM request FSM with registered handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= drop;
      case (state_q)
        ST_IDLE: begin
          if (wr_req) begin
            state_q <= ST_WRITE;
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            addr_q  <= ptr_q;
            wdata_q <= cpu_dout;
          end else if (rd_req) begin
            state_q <= ST_READ;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= rd_addr;
          end
        end
        ST_WRITE, ST_READ: begin
          if (vram_ack) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  // Read-ahead buffer: filled by prefetch completion or by a data write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rbuf_q <= 8'h00;
    end else begin
      if (state_q == ST_READ && vram_ack) rbuf_q <= vram_rdata;
      if (ev_dwr) rbuf_q <= cpu_dout;
    end
  end

  // Status flags and registered interrupt output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_q     <= 1'b0;
      c_q     <= 1'b0;
      n_int_q <= 1'b1;
    end else begin
      f_q     <= f_d;
      c_q     <= c_d;
      n_int_q <= ~(f_q & regs_q[1][5]);
    end
  end

`ifdef VDP_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt_q;
  // Saturating count of dropped accesses, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovr_cnt_q <= 8'h00;
    end else if (drop && ovr_cnt_q != 8'hFF) begin
      ovr_cnt_q <= ovr_cnt_q + 8'd1;
    end
  end
  assign overrun_cnt = ovr_cnt_q;
`else
  assign overrun_cnt = 8'h00;
`endif

  // CPU read data select
  always_comb begin
    cpu_din = 8'hFF;
    if (rd_data_m) begin
      cpu_din = rbuf_q;
    end else if (rd_ctrl_m) begin
      cpu_din = {f_q, too_many_sprites, c_q,
                 too_many_sprites ? sprite5 : 5'h1F};
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_regs
    assign regs[8*gi +: 8] = regs_q[gi];
  end

  assign vram_req   = req_q;
  assign vram_we    = we_q;
  assign vram_addr  = addr_q;
  assign vram_wdata = wdata_q;
  assign n_int      = n_int_q;
  assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_vdp_cpu_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_vdp_cpu_if
// Purpose  : Directed bench for vdp_cpu_if with a VRAM responder and a
//            scoreboard of expected VRAM accesses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vdp_cpu_if;

  localparam logic [7:0] DP = 8'hBE;
  localparam logic [7:0] CP = 8'hBF;
  localparam int ACK_LAT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_edge = 1'b0;
  logic [7:0]  cpu_addr = 8'h00;
  logic [7:0]  cpu_dout = 8'h00;
  logic        n_iowr = 1'b1;
  logic        n_iord = 1'b1;
  logic [7:0]  cpu_din;
  logic        vram_req, vram_we;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata = 8'h00;
  logic        vram_ack = 1'b0;
  logic        interrupt_flag = 1'b0;
  logic        sprite_collision = 1'b0;
  logic        too_many_sprites = 1'b0;
  logic [4:0]  sprite5 = 5'h00;
  logic [63:0] regs;
  logic        n_int, overrun;
  logic [7:0]  overrun_cnt;

  vdp_cpu_if #(.DATA_PORT(DP), .CTRL_PORT(CP), .ADDR_BITS(14)) dut (
    .clk(clk), .reset(reset), .cpu_edge(cpu_edge), .cpu_addr(cpu_addr),
    .cpu_dout(cpu_dout), .n_iowr(n_iowr), .n_iord(n_iord), .cpu_din(cpu_din),
    .vram_req(vram_req), .vram_we(vram_we), .vram_addr(vram_addr),
    .vram_wdata(vram_wdata), .vram_rdata(vram_rdata), .vram_ack(vram_ack),
    .interrupt_flag(interrupt_flag), .sprite_collision(sprite_collision),
    .too_many_sprites(too_many_sprites), .sprite5(sprite5), .regs(regs),
    .n_int(n_int), .overrun(overrun), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [22:0] exp_q [$];
  logic [22:0] obs_q [$];
  logic [7:0]  mem [0:16383];
  int          ack_cnt = 0;
  logic        hold_ack = 1'b0;
  int          ovr_seen = 0;

  // VRAM responder: ack ACK_LAT clk after the request appears
  always @(posedge clk) begin
    vram_ack <= 1'b0;
    if (!vram_req) begin
      ack_cnt <= 0;
    end else if (!vram_ack && !hold_ack) begin
      if (ack_cnt == ACK_LAT - 1) begin
        vram_ack <= 1'b1;
        ack_cnt  <= 0;
        obs_q.push_back({vram_we, vram_addr, vram_we ? vram_wdata : 8'h00});
        if (vram_we) mem[vram_addr] <= vram_wdata;
        else         vram_rdata     <= mem[vram_addr];
      end else begin
        ack_cnt <= ack_cnt + 1;
      end
    end
  end

  always @(posedge clk) if (overrun) ovr_seen <= ovr_seen + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [22:0] acc(input logic we, input logic [13:0] a, input logic [7:0] d);
    return {we, a, d};
  endfunction

  task automatic edge_pulse();
    @(negedge clk); cpu_edge = 1'b1;
    @(negedge clk); cpu_edge = 1'b0;
  endtask

  task automatic io_write(input logic [7:0] port, input logic [7:0] data);
    @(negedge clk); cpu_addr = port; cpu_dout = data; n_iowr = 1'b0;
    edge_pulse();
    edge_pulse();
    @(negedge clk); n_iowr = 1'b1;
    edge_pulse();
  endtask

  task automatic io_read(input logic [7:0] port, input logic int_at_end, output logic [7:0] data);
    @(negedge clk); cpu_addr = port; n_iord = 1'b0;
    edge_pulse();
    data = cpu_din;
    edge_pulse();
    @(negedge clk); n_iord = 1'b1;
    @(negedge clk); cpu_edge = 1'b1; interrupt_flag = int_at_end;
    @(negedge clk); cpu_edge = 1'b0; interrupt_flag = 1'b0;
  endtask

  // Wait for the next completed VRAM access and compare with the scoreboard
  task automatic check_access(input string tag);
    logic [22:0] o, e;
    int n;
    n = 0;
    while (obs_q.size() == 0 && n < 200) begin @(negedge clk); n++; end
    chk({tag, "_seen"}, 64'(obs_q.size() != 0), 64'd1);
    if (obs_q.size() != 0) begin
      o = obs_q.pop_front();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 23'h7FFFFF;
      chk(tag, 64'(o), 64'(e));
    end
    n = 0;
    while (vram_req && n < 50) begin @(negedge clk); n++; end
  endtask

  initial begin
    logic [7:0] rd;
    int ovr0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_regs", regs, 64'h0);
    chk("rst_n_int", 64'(n_int), 64'd1);
    chk("rst_req", 64'(vram_req), 64'd0);
    chk("rst_we", 64'(vram_we), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_ovr_cnt", 64'(overrun_cnt), 64'd0);
    chk("rst_din_idle", 64'(cpu_din), 64'hFF);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Register write: reg1 <= E2, no VRAM traffic
    io_write(CP, 8'hE2);
    io_write(CP, 8'h81);
    chk("reg1_write", 64'(regs[15:8]), 64'hE2);
    chk("reg_other", 64'({regs[63:16], regs[7:0]}), 64'h0);
    repeat (5) @(negedge clk);
    chk("reg_no_vram", 64'(obs_q.size()), 64'd0);

    // Write setup 3800 then two data writes
    io_write(CP, 8'h00);
    io_write(CP, 8'h78);
    exp_q.push_back(acc(1'b1, 14'h3800, 8'hAA));
    io_write(DP, 8'hAA);
    check_access("wr_3800");
    exp_q.push_back(acc(1'b1, 14'h3801, 8'h55));
    io_write(DP, 8'h55);
    check_access("wr_3801");
    exp_q.push_back(acc(1'b1, 14'h3802, 8'h5A));
    io_write(DP, 8'h5A);
    check_access("wr_3802_ptr");

    // Preload 0100/0101 through the data port, then read them back
    io_write(CP, 8'h00);
    io_write(CP, 8'h41);
    exp_q.push_back(acc(1'b1, 14'h0100, 8'h11));
    io_write(DP, 8'h11);
    check_access("wr_0100");
    exp_q.push_back(acc(1'b1, 14'h0101, 8'h22));
    io_write(DP, 8'h22);
    check_access("wr_0101");
    io_write(CP, 8'h00);
    exp_q.push_back(acc(1'b0, 14'h0100, 8'h00));
    io_write(CP, 8'h01);
    check_access("prefetch_0100");
    exp_q.push_back(acc(1'b0, 14'h0101, 8'h00));
    io_read(DP, 1'b0, rd);
    chk("read_0100", 64'(rd), 64'h11);
    check_access("prefetch_0101");
    exp_q.push_back(acc(1'b0, 14'h0102, 8'h00));
    io_read(DP, 1'b0, rd);
    chk("read_0101", 64'(rd), 64'h22);
    check_access("prefetch_0102");
    exp_q.push_back(acc(1'b1, 14'h0102, 8'h77));
    io_write(DP, 8'h77);
    check_access("wr_0102_ptr");

    // Pointer wrap at 3FFF
    io_write(CP, 8'hFF);
    io_write(CP, 8'h7F);
    exp_q.push_back(acc(1'b1, 14'h3FFF, 8'h3C));
    io_write(DP, 8'h3C);
    check_access("wr_3fff");
    exp_q.push_back(acc(1'b1, 14'h0000, 8'h3D));
    io_write(DP, 8'h3D);
    check_access("wr_wrap_0000");

    // Status flags and interrupt
    io_write(CP, 8'h20);
    io_write(CP, 8'h81);
    chk("reg1_20", 64'(regs[15:8]), 64'h20);
    @(negedge clk); interrupt_flag = 1'b1;
    @(negedge clk); interrupt_flag = 1'b0;
    repeat (2) @(negedge clk);
    chk("n_int_low", 64'(n_int), 64'd0);
    io_read(CP, 1'b0, rd);
    chk("status_9f", 64'(rd), 64'h9F);
    repeat (2) @(negedge clk);
    chk("n_int_cleared", 64'(n_int), 64'd1);
    io_read(CP, 1'b1, rd);
    chk("status_1f", 64'(rd), 64'h1F);
    repeat (2) @(negedge clk);
    chk("n_int_set_wins", 64'(n_int), 64'd0);
    @(negedge clk); sprite_collision = 1'b1;
    @(negedge clk); sprite_collision = 1'b0;
    too_many_sprites = 1'b1; sprite5 = 5'h07;
    io_read(CP, 1'b0, rd);
    chk("status_e7", 64'(rd), 64'hE7);
    too_many_sprites = 1'b0;
    io_read(CP, 1'b0, rd);
    chk("status_after_clr", 64'(rd), 64'h1F);
    io_read(8'h10, 1'b0, rd);
    chk("other_port_ff", 64'(rd), 64'hFF);

    // Overrun: second write while the first is still outstanding
    io_write(CP, 8'h00);
    io_write(CP, 8'h50);
    hold_ack = 1'b1;
    ovr0 = ovr_seen;
    exp_q.push_back(acc(1'b1, 14'h1000, 8'h01));
    io_write(DP, 8'h01);
    io_write(DP, 8'h02);
    repeat (2) @(negedge clk);
    chk("overrun_pulses", 64'(ovr_seen - ovr0), 64'd1);
    hold_ack = 1'b0;
    check_access("wr_1000");
    exp_q.push_back(acc(1'b1, 14'h1002, 8'h03));
    io_write(DP, 8'h03);
    check_access("wr_1002_ptr");
`ifdef VDP_OVERRUN_CNT_EN
    chk("overrun_cnt", 64'(overrun_cnt), 64'd1);
`else
    chk("overrun_cnt", 64'(overrun_cnt), 64'd0);
`endif

    // Asynchronous reset while a request is outstanding
    hold_ack = 1'b1;
    io_write(DP, 8'h44);
    @(negedge clk);
    chk("req_pending", 64'(vram_req), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_req_drop", 64'(vram_req), 64'd0);
    chk("async_regs", regs, 64'h0);
    chk("async_ovr_cnt", 64'(overrun_cnt), 64'd0);
    @(negedge clk); reset = 1'b0; hold_ack = 1'b0;
    io_write(CP, 8'h00);
    io_write(CP, 8'h40);
    exp_q.push_back(acc(1'b1, 14'h0000, 8'h99));
    io_write(DP, 8'h99);
    check_access("post_reset_wr");

    repeat (10) @(negedge clk);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("obs_q_empty", 64'(obs_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
